// File: rtl/rob_retire_buffer.sv
// In-order reorder buffer: dispatch into the tail, CDB completion, up to C_RT_NUM head retires per cycle.
// Define ROB_RETIRE_COUNT_EN to add rt_count_o, a running count of retired instructions.
module rob_retire_buffer #(
    parameter int unsigned C_ROB_ENTRY_NUM  = 32,
    parameter int unsigned C_DP_NUM         = 2,
    parameter int unsigned C_CDB_NUM        = 2,
    parameter int unsigned C_RT_NUM         = 2,
    parameter int unsigned C_ARCH_REG_WIDTH = 5,
    parameter int unsigned C_TAG_IDX_WIDTH  = 6,
    localparam int unsigned IDX_W = $clog2(C_ROB_ENTRY_NUM),
    localparam int unsigned PTR_W = IDX_W + 1,
    localparam int unsigned DPN_W = $clog2(C_DP_NUM + 1),
    localparam int unsigned RTN_W = $clog2(C_RT_NUM + 1),
    localparam int unsigned AW    = C_ARCH_REG_WIDTH,
    localparam int unsigned TW    = C_TAG_IDX_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [DPN_W-1:0]              dp_num_i,
    input  logic [C_DP_NUM*AW-1:0]        dp_arch_reg_i,
    input  logic [C_DP_NUM*TW-1:0]        dp_tag_i,
    input  logic [C_DP_NUM*TW-1:0]        dp_tag_old_i,
    input  logic [C_DP_NUM-1:0]           dp_wr_en_i,
    output logic [DPN_W-1:0]              dp_avail_o,
    output logic [C_DP_NUM*IDX_W-1:0]     dp_rob_idx_o,
    input  logic [C_CDB_NUM-1:0]          cdb_valid_i,
    input  logic [C_CDB_NUM*IDX_W-1:0]    cdb_rob_idx_i,
    input  logic [C_CDB_NUM-1:0]          cdb_br_mispredict_i,
    output logic [C_RT_NUM-1:0]           rt_valid_o,
    output logic [C_RT_NUM-1:0]           rt_wr_en_o,
    output logic [C_RT_NUM*AW-1:0]        rt_arch_reg_o,
    output logic [C_RT_NUM*TW-1:0]        rt_phy_reg_o,
    output logic [C_RT_NUM*TW-1:0]        rt_tag_old_o,
`ifdef ROB_RETIRE_COUNT_EN
    output logic [31:0]                   rt_count_o,
`endif
    output logic                          rollback_o
);

    logic [C_ROB_ENTRY_NUM-1:0] valid_q, valid_d;
    logic [C_ROB_ENTRY_NUM-1:0] cmpl_q, cmpl_d;
    logic [C_ROB_ENTRY_NUM-1:0] misp_q, misp_d;
    logic [C_ROB_ENTRY_NUM-1:0] wr_en_q;
    logic [AW-1:0]              arch_q  [C_ROB_ENTRY_NUM];
    logic [TW-1:0]              tag_q   [C_ROB_ENTRY_NUM];
    logic [TW-1:0]              told_q  [C_ROB_ENTRY_NUM];
    logic [PTR_W-1:0]           head_q, head_d, tail_q, tail_d;

    logic [PTR_W-1:0]           count_c, free_c;
    logic [DPN_W-1:0]           dp_eff_c;
    logic [C_DP_NUM-1:0]        dp_we_c;
    logic [IDX_W-1:0]           dp_idx_c [C_DP_NUM];
    logic [IDX_W-1:0]           rt_idx_c [C_RT_NUM];
    logic [C_RT_NUM-1:0]        rt_ok_c;
    logic [RTN_W-1:0]           rt_num_c;
    logic                       rollback_c;
    logic                       chain_c;

    // Retire selection: contiguous completed head entries, stopping after a mispredicted branch
    always_comb begin
        rt_ok_c       = '0;
        rt_num_c      = '0;
        rollback_c    = 1'b0;
        chain_c       = rst_i;
        rt_wr_en_o    = '0;
        rt_arch_reg_o = '0;
        rt_phy_reg_o  = '0;
        rt_tag_old_o  = '0;
        for (int j = 0; j < C_RT_NUM; j++) begin
            rt_idx_c[j] = head_q[IDX_W-1:0] + IDX_W'(j);
            if (chain_c && valid_q[rt_idx_c[j]] && cmpl_q[rt_idx_c[j]]) begin
                rt_ok_c[j]               = 1'b1;
                rt_num_c                 = rt_num_c + RTN_W'(1);
                rt_wr_en_o[j]            = wr_en_q[rt_idx_c[j]];
                rt_arch_reg_o[j*AW +: AW] = arch_q[rt_idx_c[j]];
                rt_phy_reg_o[j*TW +: TW]  = tag_q[rt_idx_c[j]];
                rt_tag_old_o[j*TW +: TW]  = told_q[rt_idx_c[j]];
                if (misp_q[rt_idx_c[j]]) begin
                    rollback_c = 1'b1;
                    chain_c    = 1'b0;
                end
            end else begin
                chain_c = 1'b0;
            end
        end
        rt_valid_o = rt_ok_c;
        rollback_o = rollback_c;
    end

    // Dispatch capacity and lane index assignment; writes are clamped to the free space
    always_comb begin
        count_c      = tail_q - head_q;
        free_c       = PTR_W'(C_ROB_ENTRY_NUM) - count_c;
        dp_avail_o   = (free_c >= PTR_W'(C_DP_NUM)) ? DPN_W'(C_DP_NUM) : DPN_W'(free_c);
        dp_eff_c     = (dp_num_i > dp_avail_o) ? dp_avail_o : dp_num_i;
        dp_we_c      = '0;
        dp_rob_idx_o = '0;
        for (int k = 0; k < C_DP_NUM; k++) begin
            dp_idx_c[k]                    = tail_q[IDX_W-1:0] + IDX_W'(k);
            dp_rob_idx_o[k*IDX_W +: IDX_W] = dp_idx_c[k];
            dp_we_c[k]                     = !rollback_c && (k < int'(dp_eff_c));
        end
    end

    // Entry status next-state: retire clears, dispatch allocates, CDB marks complete
    always_comb begin
        valid_d = valid_q;
        cmpl_d  = cmpl_q;
        misp_d  = misp_q;
        head_d  = head_q + PTR_W'(rt_num_c);
        tail_d  = tail_q + PTR_W'(dp_eff_c);
        for (int j = 0; j < C_RT_NUM; j++) begin
            if (rt_ok_c[j]) begin
                valid_d[rt_idx_c[j]] = 1'b0;
            end
        end
        for (int k = 0; k < C_DP_NUM; k++) begin
            if (dp_we_c[k]) begin
                valid_d[dp_idx_c[k]] = 1'b1;
                cmpl_d[dp_idx_c[k]]  = 1'b0;
                misp_d[dp_idx_c[k]]  = 1'b0;
            end
        end
        for (int c = 0; c < C_CDB_NUM; c++) begin
            if (cdb_valid_i[c] && valid_q[cdb_rob_idx_i[c*IDX_W +: IDX_W]]) begin
                cmpl_d[cdb_rob_idx_i[c*IDX_W +: IDX_W]] = 1'b1;
                misp_d[cdb_rob_idx_i[c*IDX_W +: IDX_W]] =
                    misp_q[cdb_rob_idx_i[c*IDX_W +: IDX_W]] | cdb_br_mispredict_i[c];
            end
        end
        if (rollback_c) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            cmpl_q  <= '0;
            misp_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            valid_q <= valid_d;
            cmpl_q  <= cmpl_d;
            misp_q  <= misp_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Payload storage needs no reset; valid_q gates every read
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < C_DP_NUM; k++) begin
            if (dp_we_c[k]) begin
                wr_en_q[dp_idx_c[k]] <= dp_wr_en_i[k];
                arch_q[dp_idx_c[k]]  <= dp_arch_reg_i[k*AW +: AW];
                tag_q[dp_idx_c[k]]   <= dp_tag_i[k*TW +: TW];
                told_q[dp_idx_c[k]]  <= dp_tag_old_i[k*TW +: TW];
            end
        end
    end

`ifdef ROB_RETIRE_COUNT_EN
    logic [31:0] rt_count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rt_count_q <= '0;
        end else begin
            rt_count_q <= rt_count_q + 32'(rt_num_c);
        end
    end

    assign rt_count_o = rt_count_q;
`endif

endmodule

// File: tb/tb_rob_retire_buffer.sv
// Randomised bench for rob_retire_buffer against a queue-based model of the ROB, plus directed scenarios.
module tb_rob_retire_buffer;

    localparam int N = 32, DP = 2, CDB = 2, RT = 2, AW = 5, TW = 6, IW = 5, DW = 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [DW-1:0]     dp_num_i;
    logic [DP*AW-1:0]  dp_arch_reg_i;
    logic [DP*TW-1:0]  dp_tag_i, dp_tag_old_i;
    logic [DP-1:0]     dp_wr_en_i;
    logic [DW-1:0]     dp_avail_o;
    logic [DP*IW-1:0]  dp_rob_idx_o;
    logic [CDB-1:0]    cdb_valid_i;
    logic [CDB*IW-1:0] cdb_rob_idx_i;
    logic [CDB-1:0]    cdb_br_mispredict_i;
    logic [RT-1:0]     rt_valid_o, rt_wr_en_o;
    logic [RT*AW-1:0]  rt_arch_reg_o;
    logic [RT*TW-1:0]  rt_phy_reg_o, rt_tag_old_o;
    logic              rollback_o;
`ifdef ROB_RETIRE_COUNT_EN
    logic [31:0]       rt_count_o;
`endif

    always #5 clk_i = ~clk_i;

    rob_retire_buffer #(
        .C_ROB_ENTRY_NUM(N), .C_DP_NUM(DP), .C_CDB_NUM(CDB), .C_RT_NUM(RT),
        .C_ARCH_REG_WIDTH(AW), .C_TAG_IDX_WIDTH(TW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .dp_num_i(dp_num_i), .dp_arch_reg_i(dp_arch_reg_i), .dp_tag_i(dp_tag_i),
        .dp_tag_old_i(dp_tag_old_i), .dp_wr_en_i(dp_wr_en_i),
        .dp_avail_o(dp_avail_o), .dp_rob_idx_o(dp_rob_idx_o),
        .cdb_valid_i(cdb_valid_i), .cdb_rob_idx_i(cdb_rob_idx_i),
        .cdb_br_mispredict_i(cdb_br_mispredict_i),
        .rt_valid_o(rt_valid_o), .rt_wr_en_o(rt_wr_en_o), .rt_arch_reg_o(rt_arch_reg_o),
        .rt_phy_reg_o(rt_phy_reg_o), .rt_tag_old_o(rt_tag_old_o),
`ifdef ROB_RETIRE_COUNT_EN
        .rt_count_o(rt_count_o),
`endif
        .rollback_o(rollback_o)
    );

    typedef struct {
        logic [AW-1:0] arch;
        logic [TW-1:0] tag;
        logic [TW-1:0] told;
        bit            wr;
        bit            cmp;
        bit            misp;
    } ent_t;

    ent_t        rob[$];
    int          m_head = 0;
    int unsigned m_cnt  = 0;
    logic [TW-1:0] amt [N];
    bit          ready  = 1'b0;
    int          tests  = 0;
    int          fails  = 0;

    logic [RT-1:0]    e_valid, e_wr;
    logic [RT*AW-1:0] e_arch;
    logic [RT*TW-1:0] e_phy, e_told;
    logic             e_rb;
    int               e_n;
    logic [DW-1:0]    e_avail;
    logic [DP*IW-1:0] e_idx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs straight from the in-order queue: oldest entries first
    function automatic void calc_exp();
        bit go = 1'b1;
        e_valid = '0; e_wr = '0; e_arch = '0; e_phy = '0; e_told = '0; e_rb = 1'b0; e_n = 0;
        for (int j = 0; j < RT; j++) begin
            if (go && rst_i && j < rob.size() && rob[j].cmp) begin
                e_valid[j]           = 1'b1;
                e_wr[j]              = rob[j].wr;
                e_arch[j*AW +: AW]   = rob[j].arch;
                e_phy[j*TW +: TW]    = rob[j].tag;
                e_told[j*TW +: TW]   = rob[j].told;
                e_n++;
                if (rob[j].misp) begin
                    e_rb = 1'b1;
                    go   = 1'b0;
                end
            end else begin
                go = 1'b0;
            end
        end
        e_avail = DW'((N - rob.size() < DP) ? N - rob.size() : DP);
        for (int k = 0; k < DP; k++) e_idx[k*IW +: IW] = IW'((m_head + rob.size() + k) % N);
    endfunction

    function automatic void update_model();
        if (!rst_i) begin
            rob.delete();
            m_head = 0;
            m_cnt  = 0;
        end else begin
            int sz;
            int eff;
            m_cnt += e_n;
            for (int j = 0; j < RT; j++)
                if (e_wr[j]) amt[e_arch[j*AW +: AW]] = e_phy[j*TW +: TW];
            if (e_rb) begin
                rob.delete();
                m_head = 0;
            end else begin
                sz = rob.size();
                for (int c = 0; c < CDB; c++) begin
                    if (cdb_valid_i[c]) begin
                        int p;
                        p = (int'(cdb_rob_idx_i[c*IW +: IW]) - m_head + N) % N;
                        if (p < sz) begin
                            ent_t e;
                            e = rob[p];
                            e.cmp = 1'b1;
                            if (cdb_br_mispredict_i[c]) e.misp = 1'b1;
                            rob[p] = e;
                        end
                    end
                end
                eff = (int'(dp_num_i) < int'(e_avail)) ? int'(dp_num_i) : int'(e_avail);
                repeat (e_n) void'(rob.pop_front());
                m_head = (m_head + e_n) % N;
                for (int k = 0; k < eff; k++) begin
                    ent_t e;
                    e.arch = dp_arch_reg_i[k*AW +: AW];
                    e.tag  = dp_tag_i[k*TW +: TW];
                    e.told = dp_tag_old_i[k*TW +: TW];
                    e.wr   = dp_wr_en_i[k];
                    e.cmp  = 1'b0;
                    e.misp = 1'b0;
                    rob.push_back(e);
                end
            end
        end
    endfunction

    task automatic check_outputs();
        chk("rt_valid", 64'(rt_valid_o), 64'(e_valid));
        chk("rt_wr_en", 64'(rt_wr_en_o), 64'(e_wr));
        chk("rt_arch_reg", 64'(rt_arch_reg_o), 64'(e_arch));
        chk("rt_phy_reg", 64'(rt_phy_reg_o), 64'(e_phy));
        chk("rt_tag_old", 64'(rt_tag_old_o), 64'(e_told));
        chk("rollback", 64'(rollback_o), 64'(e_rb));
        chk("dp_avail", 64'(dp_avail_o), 64'(e_avail));
        chk("dp_rob_idx", 64'(dp_rob_idx_o), 64'(e_idx));
`ifdef ROB_RETIRE_COUNT_EN
        chk("rt_count", 64'(rt_count_o), 64'(m_cnt));
`endif
    endtask

    // One clock: inputs already driven; compare, take the edge, advance the model
    task automatic cycle();
        calc_exp();
        #1;
        if (ready) check_outputs();
        @(posedge clk_i);
        if (!rst_i) ready = 1'b1;
        update_model();
        #1;
    endtask

    task automatic set_idle();
        rst_i = 1'b1; dp_num_i = '0; dp_arch_reg_i = '0; dp_tag_i = '0; dp_tag_old_i = '0;
        dp_wr_en_i = '0; cdb_valid_i = '0; cdb_rob_idx_i = '0; cdb_br_mispredict_i = '0;
    endtask

    task automatic do_reset();
        set_idle();
        rst_i = 1'b0;
        cycle();
    endtask

    task automatic rand_dispatch(input int n);
        dp_num_i = DW'(n);
        for (int k = 0; k < DP; k++) begin
            dp_arch_reg_i[k*AW +: AW] = AW'($urandom);
            dp_tag_i[k*TW +: TW]      = TW'($urandom);
            dp_tag_old_i[k*TW +: TW]  = TW'($urandom);
            dp_wr_en_i[k]             = 1'($urandom);
        end
    endtask

    task automatic rand_inputs(input int pc);
        rst_i = ($urandom_range(0, 999) != 0);
        calc_exp();
        rand_dispatch($urandom_range(0, 2));
        for (int c = 0; c < CDB; c++) begin
            int p;
            cdb_valid_i[c]         = ($urandom_range(0, 99) < pc);
            cdb_br_mispredict_i[c] = ($urandom_range(0, 99) < 4);
            if (rob.size() > e_n && $urandom_range(0, 3) != 0)
                p = $urandom_range(e_n, rob.size() - 1);
            else
                p = $urandom_range(0, N - 1);
            cdb_rob_idx_i[c*IW +: IW] = IW'((m_head + p) % N);
            if (p < e_n) cdb_valid_i[c] = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) amt[i] = '0;
        set_idle();
        rst_i = 1'b0;
        repeat (3) cycle();

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            set_idle(); #1;
            chk("idle_rt_valid", 64'(rt_valid_o), 64'd0);
            chk("idle_rollback", 64'(rollback_o), 64'd0);
            chk("idle_dp_avail", 64'(dp_avail_o), 64'd2);
            cycle();
        end

        // Two-wide dispatch, complete, retire into the AMT
        set_idle();
        dp_num_i = 2'd2; dp_wr_en_i = 2'b11;
        dp_arch_reg_i = {5'd7, 5'd3}; dp_tag_i = {6'd41, 6'd40}; dp_tag_old_i = {6'd7, 6'd3};
        cycle();
        set_idle(); cdb_valid_i = 2'b11; cdb_rob_idx_i = {5'd1, 5'd0};
        cycle();
        set_idle(); #1;
        chk("pair_rt_valid", 64'(rt_valid_o), 64'b11);
        chk("pair_rt_wr_en", 64'(rt_wr_en_o), 64'b11);
        chk("pair_phy", 64'(rt_phy_reg_o), 64'({6'd41, 6'd40}));
        chk("pair_told", 64'(rt_tag_old_o), 64'({6'd7, 6'd3}));
        cycle();
        chk("amt3", 64'(amt[3]), 64'd40);
        chk("amt7", 64'(amt[7]), 64'd41);

        // Out-of-order completion holds retire until the head completes
        do_reset();
        set_idle(); rand_dispatch(2); cycle();
        set_idle(); cdb_valid_i = 2'b01; cdb_rob_idx_i = {5'd0, 5'd1}; cycle();
        set_idle(); #1;
        chk("ooo_hold0", 64'(rt_valid_o), 64'b00);
        cycle();
        set_idle(); #1;
        chk("ooo_hold1", 64'(rt_valid_o), 64'b00);
        cdb_valid_i = 2'b01; cdb_rob_idx_i = {5'd0, 5'd0}; cycle();
        set_idle(); #1;
        chk("ooo_release", 64'(rt_valid_o), 64'b11);
        cycle();

        // Mispredicted head: lane 0 retires, rollback empties ROB, same-cycle dispatch dropped
        do_reset();
        set_idle(); rand_dispatch(2); cycle();
        set_idle(); cdb_valid_i = 2'b11; cdb_rob_idx_i = {5'd1, 5'd0}; cdb_br_mispredict_i = 2'b01;
        cycle();
        set_idle(); rand_dispatch(2); #1;
        chk("rb_rt_valid", 64'(rt_valid_o), 64'b01);
        chk("rb_rollback", 64'(rollback_o), 64'd1);
        cycle();
        set_idle(); #1;
        chk("rb_after_avail", 64'(dp_avail_o), 64'd2);
        chk("rb_after_valid", 64'(rt_valid_o), 64'b00);
        chk("rb_after_idx", 64'(dp_rob_idx_o), 64'({5'd1, 5'd0}));
        cycle();

        // Fill to capacity, retire one
        do_reset();
        for (int i = 0; i < N / 2; i++) begin
            set_idle(); rand_dispatch(2); cycle();
        end
        set_idle(); #1;
        chk("full_avail", 64'(dp_avail_o), 64'd0);
        cdb_valid_i = 2'b01; cdb_rob_idx_i = {5'd0, 5'd0}; cycle();
        set_idle(); #1;
        chk("full_rt_valid", 64'(rt_valid_o), 64'b01);
        cycle();
        set_idle(); #1;
        chk("full_avail_after", 64'(dp_avail_o), 64'd1);

        // Random traffic alternating slow and fast completion, crossing the wrap point repeatedly
        for (int i = 0; i < 4000; i++) begin
            rand_inputs(((i / 250) % 2 == 1) ? 70 : 12);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rob_retire_buffer.md
Name: rob_retire_buffer

Overview:
- In-order reorder buffer that tracks dispatched instructions, records completion from the CDB, and retires up to C_RT_NUM completed head entries per cycle.
- Sits directly upstream of the architectural map table: each retire lane drives an AMT write (wr_en, arch_reg, phy_reg) plus rollback_o.
- Also returns the previous mapping (told) to the free list.

Parameters:
- C_ROB_ENTRY_NUM, 32, number of ROB entries; power of two.
- C_DP_NUM, 2, dispatch lanes per cycle.
- C_CDB_NUM, 2, completion lanes per cycle.
- C_RT_NUM, 2, retire lanes per cycle; equals the AMT retire width.
- C_ARCH_REG_WIDTH, 5, architectural register index width.
- C_TAG_IDX_WIDTH, 6, physical register tag width.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous reset, active-low (0 = reset).
- dp_num_i  in  clog2(C_DP_NUM+1)  number of instructions dispatched this cycle, lanes 0..dp_num_i-1.
- dp_arch_reg_i  in  C_DP_NUM x C_ARCH_REG_WIDTH  destination arch reg per lane.
- dp_tag_i  in  C_DP_NUM x C_TAG_IDX_WIDTH  new physical tag per lane.
- dp_tag_old_i  in  C_DP_NUM x C_TAG_IDX_WIDTH  previous mapping per lane.
- dp_wr_en_i  in  C_DP_NUM  lane has a destination register.
- dp_avail_o  out  clog2(C_DP_NUM+1)  min(free entries, C_DP_NUM).
- dp_rob_idx_o  out  C_DP_NUM x clog2(C_ROB_ENTRY_NUM)  index assigned to each lane (tail+lane).
- cdb_valid_i  in  C_CDB_NUM  completion valid.
- cdb_rob_idx_i  in  C_CDB_NUM x clog2(C_ROB_ENTRY_NUM)  completing entry.
- cdb_br_mispredict_i  in  C_CDB_NUM  completing branch was mispredicted.
- rt_valid_o  out  C_RT_NUM  lane retires this cycle.
- rt_wr_en_o  out  C_RT_NUM  AMT write enable (rt_valid_o AND entry wr_en).
- rt_arch_reg_o  out  C_RT_NUM x C_ARCH_REG_WIDTH  to AMT.
- rt_phy_reg_o  out  C_RT_NUM x C_TAG_IDX_WIDTH  to AMT.
- rt_tag_old_o  out  C_RT_NUM x C_TAG_IDX_WIDTH  to free list.
- rollback_o  out  1  a retiring entry is a mispredicted branch.

Behaviour:
- Storage: circular buffer with head/tail pointers, each one bit wider than the index; wrap bit separates full from empty. Each entry holds: valid, complete, mispredict, wr_en, arch_reg, tag, tag_old.
- Reset (rst_i=0 at posedge): all entries invalid, head=tail=0.
  - Combinational outputs then follow the empty state: rt_* = 0, rollback_o = 0, dp_avail_o = C_DP_NUM.
- Occupancy: count = tail - head over the full pointer width; free = C_ROB_ENTRY_NUM - count.
- Dispatch:
  - Lanes 0..dp_num_i-1 write entries tail..tail+dp_num_i-1 (modulo entries), with valid=1, complete=0.
  - tail advances by dp_num_i.
  - dp_num_i > dp_avail_o is illegal; the block still writes only dp_avail_o entries.
- Completion: each valid CDB lane sets complete=1 on its entry and ORs in mispredict. Completing an invalid entry is ignored.
- Retire (combinational from registered state, zero latency):
  - Lane j retires iff entry head+j is valid and complete, and all lanes <j retire.
  - Lane j is additionally blocked if any lane <j is a mispredicted branch.
  - rt_* outputs come from entry head+j.
  - head advances by the number of retiring lanes at the posedge.
- Rollback:
  - rollback_o=1 in the cycle a retiring lane holds mispredict=1; that lane retires normally, including its AMT write.
  - At that posedge, all entries are invalidated and head=tail=0.
  - Dispatch and completion in the same cycle are discarded.
- Simultaneous events:
  - Dispatch, completion and retire in one cycle touch disjoint entries and all take effect.
  - A completion landing on an entry retiring that cycle is illegal.
- Full: dp_avail_o=0 while count = C_ROB_ENTRY_NUM. Empty: rt_valid_o = 0.
- Wrap-around: indices wrap modulo C_ROB_ENTRY_NUM, including multi-lane dispatch or retire that crosses entry 31 to entry 0.
- Reset mid-operation: all in-flight entries are dropped; no retire output in the reset cycle.

Optional Feature:
- Macro ROB_RETIRE_COUNT_EN.
- When defined: adds output rt_count_o [31:0], a registered count of retired instructions.
  - Increments by popcount(rt_valid_o) each cycle; wraps at 2^32.
  - Cleared on reset; not cleared by rollback.
- When undefined: the port and counter are absent.

Test Plan:
- Reset then idle -> rt_valid_o=00, rollback_o=0, dp_avail_o=2 for 5 cycles.
- Dispatch 2 (arch 3→tag 40 old 3; arch 7→tag 41 old 7), complete both next cycle -> following cycle rt_valid_o=11, rt_wr_en_o=11, rt_phy_reg_o={41,40}, rt_tag_old_o={7,3}; AMT entries 3/7 read 40/41 after the edge.
- Out-of-order completion: entries 0,1 dispatched, entry 1 completes first -> rt_valid_o=00 until entry 0 completes, then 11 in one cycle.
- Fill 32 entries -> dp_avail_o=0; retire 1 -> dp_avail_o=1; continue dispatch/retire across index 31→0 -> correct indices and data.
- Entries 0 (mispredict) and 1 complete together -> rt_valid_o=01, rollback_o=1; next cycle ROB empty, dp_avail_o=2; a dispatch in the rollback cycle is discarded.
- ROB_RETIRE_COUNT_EN defined: retire 5 instructions, rollback, retire 2 more -> rt_count_o=7; rst_i=0 -> rt_count_o=0.
